// File: rtl/psum_requant_pack.sv
// psum_requant_pack: requantizes finished partial sums (shift + clamp) and packs them LSB-first
// into 32-bit words behind a small output FIFO. Define REQUANT_ROUND_EN for round-half-up.
module psum_requant_pack #(
   parameter int BITS_PSUM  = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        i_Valid,
   input  logic signed [BITS_PSUM-1:0] i_Psum,
   input  logic                        i_Last,
   input  logic [4:0]                  i_Shift,
   input  logic [1:0]                  i_OutPrec,
   output logic                        o_Valid,
   input  logic                        i_Ready,
   output logic [31:0]                 o_Data,
   output logic                        o_Stall,
   output logic                        o_Overflow,
   input  logic                        i_ClrOvf
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] STALL_CNT = CW'(FIFO_DEPTH - 1);

   typedef enum logic {ST_EMPTY, ST_FILLING} pack_state_t;

   pack_state_t   state, state_nxt;
   logic [3:0]    lane_cnt, lane_nxt;
   logic [31:0]   pack_word, pack_nxt;

   logic [4:0]    cfg_shift;
   logic [1:0]    cfg_prec;
   logic          lane_first;
   logic [4:0]    eff_shift;
   logic [1:0]    eff_prec;

   logic          q_valid, q_last;
   logic [7:0]    q_lane;
   logic [1:0]    q_prec;

   logic signed [BITS_PSUM:0] shifted;
   logic          sign_bit, fits2, fits4, fits8;
   logic [7:0]    lane_d;

   logic          push, pop, push_ok, ovf_evt;
   logic [31:0]   push_data;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   // A value is the first of its word when the pack stage will be empty after this cycle,
   // so the live config is used (and latched) for it; later lanes reuse the latched copy.
   assign lane_first = (state_nxt == ST_EMPTY);
   assign eff_shift  = lane_first ? i_Shift   : cfg_shift;
   assign eff_prec   = lane_first ? i_OutPrec : cfg_prec;

`ifdef REQUANT_ROUND_EN
   localparam logic [BITS_PSUM:0] ONE = {{BITS_PSUM{1'b0}}, 1'b1};
   logic signed [BITS_PSUM:0] psum_ext, rnd_sum;
   logic [BITS_PSUM:0]        rnd_add;

   // One bit of headroom lets a positive carry out of the adder still saturate in the clamp.
   assign psum_ext = {i_Psum[BITS_PSUM-1], i_Psum};
   assign rnd_add  = (ONE << eff_shift) >> 1;
   assign rnd_sum  = psum_ext + rnd_add;
   assign shifted  = rnd_sum >>> eff_shift;
`else
   logic signed [BITS_PSUM-1:0] trunc_val;

   assign trunc_val = i_Psum >>> eff_shift;
   assign shifted   = {trunc_val[BITS_PSUM-1], trunc_val};
`endif

   // The value fits in P signed bits when every bit above bit P-1 equals the sign.
   assign sign_bit = shifted[BITS_PSUM];
   assign fits2 = (&shifted[BITS_PSUM:1]) | ~(|shifted[BITS_PSUM:1]);
   assign fits4 = (&shifted[BITS_PSUM:3]) | ~(|shifted[BITS_PSUM:3]);
   assign fits8 = (&shifted[BITS_PSUM:7]) | ~(|shifted[BITS_PSUM:7]);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      lane_d = 8'h00;
      case (eff_prec)
         2'b00:   lane_d = fits2 ? {6'b0, shifted[1:0]} : (sign_bit ? 8'h02 : 8'h01);
         2'b01:   lane_d = fits4 ? {4'b0, shifted[3:0]} : (sign_bit ? 8'h08 : 8'h07);
         default: lane_d = fits8 ? shifted[7:0]         : (sign_bit ? 8'h80 : 8'h7F);
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         q_valid   <= 1'b0;
         q_last    <= 1'b0;
         q_lane    <= 8'h00;
         q_prec    <= 2'b00;
         cfg_shift <= 5'd0;
         cfg_prec  <= 2'b00;
      end else begin
         q_valid <= i_Valid;
         q_last  <= i_Valid & i_Last;
         if (i_Valid) begin
            q_lane <= lane_d;
            q_prec <= eff_prec;
         end
         if (i_Valid && lane_first) begin
            cfg_shift <= i_Shift;
            cfg_prec  <= i_OutPrec;
         end
      end
   end

   logic [3:0]  last_lane;
   logic [31:0] lane_word, merged;

   always_comb begin
      last_lane = 4'd3;
      lane_word = 32'h0;
      case (q_prec)
         2'b00: begin
            last_lane = 4'd15;
            lane_word = 32'(q_lane[1:0]) << {lane_cnt, 1'b0};
         end
         2'b01: begin
            last_lane = 4'd7;
            lane_word = 32'(q_lane[3:0]) << {lane_cnt, 2'b00};
         end
         default: begin
            last_lane = 4'd3;
            lane_word = 32'(q_lane) << {lane_cnt, 3'b000};
         end
      endcase
   end

   assign merged = pack_word | lane_word;

   always_comb begin
      state_nxt = state;
      lane_nxt  = lane_cnt;
      pack_nxt  = pack_word;
      push      = 1'b0;
      push_data = merged;
      if (q_valid) begin
         if (q_last || (lane_cnt == last_lane)) begin
            push      = 1'b1;
            state_nxt = ST_EMPTY;
            lane_nxt  = 4'd0;
            pack_nxt  = 32'h0;
         end else begin
            state_nxt = ST_FILLING;
            lane_nxt  = lane_cnt + 4'd1;
            pack_nxt  = merged;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ST_EMPTY;
         lane_cnt  <= 4'd0;
         pack_word <= 32'h0;
      end else begin
         state     <= state_nxt;
         lane_cnt  <= lane_nxt;
         pack_word <= pack_nxt;
      end
   end

   // A push into a full FIFO still succeeds when the head leaves in the same cycle.
   assign o_Valid = (count != '0);
   assign pop     = o_Valid & i_Ready;
   assign push_ok = push & ((count != FULL_CNT) | pop);
   assign ovf_evt = push & ~push_ok;
   assign o_Stall = (count >= STALL_CNT);
   assign o_Data  = o_Valid ? mem[rd_ptr] : 32'h0;

   // NOTE: the storage array has no reset; o_Data is gated by the reset-cleared count instead.
   always_ff @(posedge CLK) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_Overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      count <= count + CW'(1);
         else if (pop && !push_ok) count <= count - CW'(1);
         if (ovf_evt)       o_Overflow <= 1'b1;
         else if (i_ClrOvf) o_Overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_psum_requant_pack.sv
// Self-checking bench for psum_requant_pack: directed corner cases plus randomized traffic
// scored against an arithmetic reference model of requantization and packing.
module tb_psum_requant_pack;
   localparam int BITS_PSUM  = 32;
   localparam int FIFO_DEPTH = 4;

   logic                        CLK = 1'b0;
   logic                        RST = 1'b0;
   logic                        i_Valid = 1'b0;
   logic signed [BITS_PSUM-1:0] i_Psum = '0;
   logic                        i_Last = 1'b0;
   logic [4:0]                  i_Shift = 5'd0;
   logic [1:0]                  i_OutPrec = 2'b00;
   logic                        o_Valid;
   logic                        i_Ready = 1'b0;
   logic [31:0]                 o_Data;
   logic                        o_Stall;
   logic                        o_Overflow;
   logic                        i_ClrOvf = 1'b0;

   psum_requant_pack #(.BITS_PSUM(BITS_PSUM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .CLK(CLK), .RST(RST), .i_Valid(i_Valid), .i_Psum(i_Psum), .i_Last(i_Last),
      .i_Shift(i_Shift), .i_OutPrec(i_OutPrec), .o_Valid(o_Valid), .i_Ready(i_Ready),
      .o_Data(o_Data), .o_Stall(o_Stall), .o_Overflow(o_Overflow), .i_ClrOvf(i_ClrOvf)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
      end
   endtask

   // Every word leaving the FIFO is matched in order against the expected-word queue.
   always @(negedge CLK) begin
      if (RST && o_Valid && i_Ready) begin
         check("word_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("word_data", o_Data, exp_q.pop_front());
      end
   end

   // Reference model: requantize with plain integer arithmetic, pack by lane index.
   int          m_lane = 0;
   int          m_prec = 0;
   int          m_shift = 0;
   logic [31:0] m_word = '0;

   function automatic int prec_bits(input int pr);
      return (pr == 0) ? 2 : (pr == 1) ? 4 : 8;
   endfunction

   function automatic logic [7:0] requant(input logic signed [31:0] psum, input int sh, input int p);
      longint v, hi, lo;
      v = longint'(psum);
`ifdef REQUANT_ROUND_EN
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
`endif
      v  = v >>> sh;
      hi = (longint'(1) << (p - 1)) - 1;
      lo = -hi - 1;
      if (v > hi) v = hi;
      else if (v < lo) v = lo;
      return 8'(v & ((longint'(1) << p) - 1));
   endfunction

   task automatic model_in(input logic signed [31:0] psum, input logic last,
                           input int sh, input int pr);
      int p;
      if (m_lane == 0) begin
         m_shift = sh;
         m_prec  = pr;
         m_word  = '0;
      end
      p = prec_bits(m_prec);
      m_word = m_word | (32'(requant(psum, m_shift, p)) << (m_lane * p));
      m_lane++;
      if (m_lane == 32 / p || last) begin
         exp_q.push_back(m_word);
         m_lane = 0;
      end
   endtask

   task automatic send(input logic signed [31:0] psum, input logic last,
                       input logic [4:0] sh, input logic [1:0] pr);
      @(posedge CLK); #1;
      i_Valid = 1'b1; i_Psum = psum; i_Last = last; i_Shift = sh; i_OutPrec = pr;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
         i_Valid = 1'b0; i_Last = 1'b0;
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int c = 0;
      while ((exp_q.size() != 0 || o_Valid) && c < budget) begin
         @(posedge CLK); #1;
         c++;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check("rst_valid", 32'(o_Valid), 32'd0);
      check("rst_data", o_Data, 32'h0);
      check("rst_stall", 32'(o_Stall), 32'd0);
      check("rst_ovf", 32'(o_Overflow), 32'd0);
      RST = 1'b1;
      idle(2);

      // 8-bit lanes with clamping, and exact two-cycle latency.
      i_Ready = 1'b1;
      exp_q.push_back(32'h7FFF0201);
      send(1, 0, 5'd0, 2'b10);
      send(2, 0, 5'd0, 2'b10);
      send(-1, 0, 5'd0, 2'b10);
      send(200, 0, 5'd0, 2'b10);
      @(posedge CLK); #1;
      i_Valid = 1'b0;
      check("lat_t1_valid", 32'(o_Valid), 32'd0);
      @(posedge CLK); #1;
      check("lat_t2_valid", 32'(o_Valid), 32'd1);
      check("lat_t2_data", o_Data, 32'h7FFF0201);
      drain("drain_8b", 50);

      // 2-bit lanes: plain ones, then negative clamp to -2.
      exp_q.push_back(32'h55555555);
      exp_q.push_back(32'hAAAAAAAA);
      for (int i = 0; i < 16; i++) send(1, 0, 5'd0, 2'b00);
      for (int i = 0; i < 16; i++) send(-7, 0, 5'd0, 2'b00);
      idle(2);
      drain("drain_2b", 50);

      // Shifted value with a single-lane word.
`ifdef REQUANT_ROUND_EN
      exp_q.push_back(32'h00000014);
`else
      exp_q.push_back(32'h00000013);
`endif
      send(312, 1, 5'd4, 2'b10);
      idle(2);
      drain("drain_shift", 50);

      // Early last pads the word; the following group restarts at lane 0.
      exp_q.push_back(32'h00070605);
      exp_q.push_back(32'h0C0B0A09);
      send(5, 0, 5'd0, 2'b10);
      send(6, 0, 5'd0, 2'b10);
      send(7, 1, 5'd0, 2'b10);
      for (int i = 9; i <= 12; i++) send(i, 0, 5'd0, 2'b10);
      idle(2);
      drain("drain_last", 50);

      // Fill the FIFO with the consumer stalled; the fifth word is dropped.
      i_Ready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         logic [31:0] w;
         w = '0;
         for (int l = 0; l < 4; l++) begin
            send(j * 16 + l + 1, 0, 5'd0, 2'b10);
            w = w | (32'(j * 16 + l + 1) << (8 * l));
         end
         if (j < 4) exp_q.push_back(w);
         idle(2);
         check($sformatf("stall_w%0d", j), 32'(o_Stall), 32'(j >= 2));
         check($sformatf("ovf_w%0d", j), 32'(o_Overflow), 32'(j == 4));
      end
      i_Ready = 1'b1;
      drain("drain_full", 50);
      check("ovf_sticky", 32'(o_Overflow), 32'd1);
      i_ClrOvf = 1'b1;
      @(posedge CLK); #1;
      i_ClrOvf = 1'b0;
      check("ovf_cleared", 32'(o_Overflow), 32'd0);

      // Mid-word reset discards a queued word and a half-packed word.
      i_Ready = 1'b0;
      for (int l = 1; l <= 4; l++) send(l, 0, 5'd0, 2'b10);
      send(7, 0, 5'd0, 2'b10);
      send(8, 0, 5'd0, 2'b10);
      idle(2);
      check("pre_rst_valid", 32'(o_Valid), 32'd1);
      #2;
      RST = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_valid", 32'(o_Valid), 32'd0);
      check("mid_rst_data", o_Data, 32'h0);
      check("mid_rst_stall", 32'(o_Stall), 32'd0);
      check("mid_rst_ovf", 32'(o_Overflow), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b1;
      i_Ready = 1'b1;
      exp_q.push_back(32'h44332211);
      send(32'h11, 0, 5'd0, 2'b10);
      send(32'h22, 0, 5'd0, 2'b10);
      send(32'h33, 0, 5'd0, 2'b10);
      send(32'h44, 0, 5'd0, 2'b10);
      idle(2);
      drain("drain_after_rst", 50);

      // Random traffic honouring the stall hint; config changes mid-word must be ignored.
      for (int i = 0; i < 1500; i++) begin
         logic signed [31:0] ps;
         logic [4:0]         sh;
         logic [1:0]         pr;
         logic               lst;
         @(posedge CLK); #1;
         i_Ready = ($urandom_range(0, 3) != 0);
         ps  = $urandom_range(0, 1) ? $signed($urandom) : 32'($urandom_range(0, 600)) - 32'sd300;
         sh  = $urandom_range(0, 1) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
         pr  = 2'($urandom_range(0, 3));
         lst = ($urandom_range(0, 9) == 0);
         i_Shift   = sh;
         i_OutPrec = pr;
         if (!o_Stall && $urandom_range(0, 2) != 0) begin
            i_Valid = 1'b1; i_Psum = ps; i_Last = lst;
            model_in(ps, lst, int'(sh), int'(pr));
         end else begin
            i_Valid = 1'b0; i_Last = 1'b0;
         end
      end
      idle(1);
      i_Ready = 1'b1;
      idle(6);
      send(32'sd3, 1, 5'd0, 2'b01);
      model_in(32'sd3, 1'b1, 0, 1);
      idle(2);
      drain("drain_random", 400);
      check("rand_no_ovf", 32'(o_Overflow), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish, want finish");
      $fatal(1);
   end

endmodule

// File: doc/psum_requant_pack.md
Name: psum_requant_pack

Overview:
- Sits directly downstream of the PE-array accumulator.
- Takes each finished partial sum (accumulator result qualified by its done pulse), requantizes it, and packs results LSB-first into 32-bit words for the output activation buffer.
- Requantize = arithmetic right shift, then saturating clamp to the 2/4/8-bit output precision.
- Decouples the array from the buffer with a small FIFO and a valid/ready handshake.
- Drives a stall hint back to the array controller.

Parameters:
- BITS_PSUM, 32, width of incoming partial sum (signed).
- FIFO_DEPTH, 4, output word FIFO entries (power of 2, >=2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- i_Valid  in  1  partial sum valid; driven by the array's done pulse.
- i_Psum  in  BITS_PSUM  signed partial sum.
- i_Last  in  1  with i_Valid: last value of the group; forces emission of the partial word.
- i_Shift  in  5  right-shift amount, 0..31.
- i_OutPrec  in  2  output precision: 00=2b, 01=4b, 10=8b, 11 reserved (treated as 8b).
- o_Valid  out  1  FIFO head valid.
- i_Ready  in  1  buffer accepts head word this cycle.
- o_Data  out  32  packed output word.
- o_Stall  out  1  high when FIFO free entries < 2.
- o_Overflow  out  1  sticky; a word was dropped.
- i_ClrOvf  in  1  synchronous clear of o_Overflow.

Behaviour:
- Reset (RST low, async) clears all state: Q stage, pack register, lane counter, FIFO pointers. Outputs: o_Valid=0, o_Data=0, o_Stall=0, o_Overflow=0.
- Stage Q (registered, 1 cycle):
  - v = i_Psum >>> i_Shift (arithmetic shift).
  - Clamp v to [-2^(P-1), 2^(P-1)-1], with P = 2, 4 or 8 per i_OutPrec.
  - Keep the low P bits.
  - The valid and last flags are registered alongside.
- Config latch: i_Shift and i_OutPrec are sampled on the first value of each word (lane counter = 0) and held until the word is emitted. Changes mid-word are ignored for that word.
- Pack FSM:
  - States: EMPTY, FILLING.
  - Lanes per word N = 32/P (16, 8 or 4).
  - Each Q-valid writes lane k at bits [k*P +: P]; lane 0 is LSB.
  - Word completes when k = N-1 or Q-last = 1. On completion, push the word to the FIFO, zero-pad unused upper lanes, reset k to 0, return to EMPTY.
  - Otherwise k increments; state is FILLING.
  - EMPTY + last on lane 0: a one-lane word is emitted.
- Latency: a word-completing i_Valid in cycle t, with the FIFO empty, gives o_Valid=1 in cycle t+2 with o_Data stable.
- FIFO and handshake:
  - Pop when o_Valid && i_Ready.
  - o_Data holds until popped.
  - Push and pop in the same cycle are both honoured, including when full.
  - Push when full without a same-cycle pop: word dropped, pack register still cleared, o_Overflow set.
  - i_ClrOvf clears o_Overflow next cycle; a simultaneous overflow event wins (flag stays 1).
- o_Stall is combinational from the FIFO count: asserted at count >= FIFO_DEPTH-1. The array controller must stop issuing groups while it is high.
- i_Valid without a preceding stall check is always accepted; no input backpressure exists.
- Mid-operation reset: the partially packed word and FIFO contents are discarded; no word emitted.

Optional Feature:
- Macro: REQUANT_ROUND_EN.
- Defined: round-half-up before the shift; when i_Shift > 0, v = (i_Psum + (1 << (i_Shift-1))) >>> i_Shift.
  - Adder is BITS_PSUM+1 wide, so positive overflow saturates correctly through the clamp.
- Undefined: plain truncation toward -inf; no adder instantiated.

Test Plan:
- OutPrec=10, Shift=0, i_Psum = 1, 2, -1, 200 on consecutive cycles, i_Ready=1 -> one word 0x7FFF0201, o_Valid high exactly 2 cycles after the 4th input.
- OutPrec=00, Shift=0, sixteen i_Psum=1 -> 0x55555555. Sixteen i_Psum=-7 -> 0xAAAAAAAA (clamp to -2).
- OutPrec=10, Shift=4, i_Psum=312 with i_Last -> 0x00000014 with REQUANT_ROUND_EN, 0x00000013 without.
- OutPrec=10, values 5, 6, 7 with i_Last on 7 -> 0x00070605. Next group starts at lane 0.
- i_Ready=0, push 5 full 8b words with FIFO_DEPTH=4:
  - o_Stall rises when count reaches 3.
  - 5th word dropped, o_Overflow=1.
  - Drain gives 4 words in order.
  - i_ClrOvf clears the flag.
- Assert RST after 2 of 4 lanes -> all outputs 0 immediately. After release, 4 new values produce one correct word with no stale lanes.
